// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds the feeder state encoding, counter-width helpers and the skew index rule.
// No logic of its own; imported by the feeder and its skew generator.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feeder_state_t;

  // Element index selected for one lane on one beat, plus whether the lane is live.
  typedef struct packed {
    logic ok;
    int   idx;
  } skew_t;

  // Number of beats needed to push an NxN skewed wavefront through one side.
  function automatic int beat_count(input int n);
    return 2 * n - 1;
  endfunction

  // Beat counter width; sized so the last beat index fits without wrapping.
  function automatic int beat_cnt_w(input int n);
    return (2 * n - 1 > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  // Drain counter width; must be able to hold TIMEOUT itself.
  function automatic int drain_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Lane `lane` on beat `t` carries element t-lane when that falls inside the matrix.
  function automatic skew_t skew_idx(input int t, input int lane, input int n);
    skew_t r;
    int    d;
    d     = t - lane;
    r.ok  = (d >= 0) && (d < n);
    r.idx = r.ok ? d : 0;
    return r;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Skewed lane mux: builds one beat of A-row / B-column lanes from latched operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the beat is registered.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 4,
  parameter int TW    = 2
) (
  input  logic [N-1:0][N-1:0][WIDTH-1:0] a,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] b,
  input  logic [TW-1:0]                  t,
  output logic [1:0][N-1:0][WIDTH-1:0]   lanes
);

  skew_t s;

  // Lane i carries A[i][t-i] and B[t-i][i]; lanes outside their window stay zero.
  always_comb begin
    lanes = '0;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s = skew_idx(int'(t), i, N);
      for (int k = 0; k < N; k++) begin
        if (s.ok && (s.idx == k)) begin
          lanes[0][i] = a[i][k];
          lanes[1][i] = b[k][i];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: accepts an NxN operand pair, streams skewed lanes, returns the product.
// Latency: first beat one cycle after accept, 2N-1 beats, then up to TIMEOUT cycles waiting for finish.
// Backpressure: req_ready low from accept until the result is taken; result held while res_ready is low.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N       = 2,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] mat_a,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] mat_b,
  output logic [1:0][N-1:0][WIDTH-1:0]   array,
  output logic                          start,
  input  logic                          finish,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] Data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N-1:0][N-1:0][WIDTH-1:0] result,
  output logic                          err
);

  localparam int BEATS = beat_count(N);
  localparam int TW    = beat_cnt_w(N);
  localparam int CW    = drain_cnt_w(TIMEOUT);

  feeder_state_t state, state_d;

  logic [N-1:0][N-1:0][WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [TW-1:0]                  t_q, t_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [N-1:0][N-1:0][WIDTH-1:0] result_d;
  logic [1:0][N-1:0][WIDTH-1:0]   lanes;
  logic                           res_valid_d, err_d;
  logic                           accept, last_beat, timeout_hit;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign last_beat   = (t_q == TW'(BEATS - 1));
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state; finish is only honoured while draining, and beats a same-cycle timeout.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = FEED;
      FEED:    if (last_beat) state_d = DRAIN;
      DRAIN:   if (finish || timeout_hit) state_d = DONE;
      DONE:    if (res_valid && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next operand/counter/result values; operands are only sampled on accept.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    t_d         = '0;
    cnt_d       = '0;
    res_valid_d = res_valid;
    result_d    = result;
    err_d       = err;
    case (state)
      IDLE: begin
        if (accept) begin
          a_d = mat_a;
          b_d = mat_b;
        end
      end
      FEED: t_d = last_beat ? '0 : t_q + TW'(1);
      DRAIN: begin
        cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        if (finish) begin
          result_d    = Data;
          res_valid_d = 1'b1;
          err_d       = 1'b0;
        end else if (timeout_hit) begin
          result_d    = '0;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // The beat shown next cycle is built from next-cycle operands and beat index,
  // so the first beat appears directly after the accept edge.
  systolic_skew_gen #(.N(N), .WIDTH(WIDTH), .TW(TW)) u_skew (
    .a     (a_d),
    .b     (b_d),
    .t     (t_d),
    .lanes (lanes)
  );

  // Registered outputs and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      array     <= '0;
      start     <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      array     <= (state_d == FEED) ? lanes : '0;
      start     <= accept;
      res_valid <= res_valid_d;
      result    <= result_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Drive side of the systolic array interface: accepts two NxN operand matrices over a valid/ready handshake and emits skewed per-row/per-column streams on `array`.
- Pulses `start` with the first beat, then waits for the array's `finish`, captures `Data` and returns it over a second valid/ready handshake.
- Sits between the host/DMA layer and `systolic`; replaces hand-written stimulus sequencing.

Parameters:
- N, 2, matrix dimension; PEs per side.
- WIDTH, 4, bits per element, operand and result.
- TIMEOUT, 64, maximum cycles spent in DRAIN waiting for `finish` before the error abort.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  feeder can accept operands.
- mat_a  in  [WIDTH-1:0] x [N-1:0][N-1:0]  operand A, indexed [row][col].
- mat_b  in  [WIDTH-1:0] x [N-1:0][N-1:0]  operand B, indexed [row][col].
- array  out  [WIDTH-1:0] x [1:0][N-1:0]  stream to array; [0][i] is A row i, [1][j] is B column j.
- start  out  1  one-cycle pulse aligned with beat 0.
- finish  in  1  array done; `Data` is valid in the same cycle.
- Data  in  [WIDTH-1:0] x [N-1:0][N-1:0]  product from array.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- result  out  [WIDTH-1:0] x [N-1:0][N-1:0]  captured product.
- err  out  1  qualifies res_valid: timeout abort, result forced to 0.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, array all 0, start=0, res_valid=0, result all 0, err=0, state IDLE, counters 0. req_ready becomes 1 in the first cycle after rst falls.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch mat_a/mat_b into internal regs, clear req_ready, set beat counter t=0, go to FEED.
  - Operands are not sampled in any other state.
- FEED, one beat per cycle for t=0..2N-2:
  - array[0][i] = A[i][t-i] if 0<=t-i<N, else 0.
  - array[1][j] = B[t-j][j] if 0<=t-j<N, else 0.
  - start=1 only on the t=0 beat.
  - The first beat is driven in the cycle after the accept edge.
  - After beat 2N-2, go to DRAIN.
- DRAIN:
  - array=0, start=0; the drain counter increments each cycle.
  - When finish=1: result<=Data, res_valid<=1, err<=0, go to DONE.
  - If the counter reaches TIMEOUT with no finish: result<=0, res_valid<=1, err<=1, go to DONE.
  - finish=1 during IDLE, FEED or DONE is ignored.
- DONE:
  - Hold result/res_valid/err stable.
  - On res_valid&&res_ready, clear res_valid and err and go to IDLE; req_ready=1 in the next cycle.
  - No new request is accepted while res_valid=1.
- Counters:
  - t is $clog2(2N-1) wide and never wraps within a job.
  - The drain counter is $clog2(TIMEOUT+1) wide and saturates.
- Arithmetic: the block performs no arithmetic on data. Elements pass bit-exact; there is no width change.
- Reset mid-operation: rst in any state aborts the job. Outputs return to reset values next cycle, nothing is reported, and any latched operands are discarded.
- Simultaneous events: finish in the same cycle as the TIMEOUT limit counts as success (finish wins).

Decomposition:
- Package systolic_pkg:
  - feeder_state_t enum {IDLE, FEED, DRAIN, DONE}.
  - localparam-derived widths: BEATS=2N-1, beat-counter width, timeout-counter width.
  - function skew_idx(t,lane) returning the element index and an in-range flag.
- Sub-module systolic_skew_gen:
  - Purely combinational per-beat lane mux.
  - Generates array[1:0][N-1:0] from the latched A/B and t; the registered stage stays in systolic_feeder.

Test Plan:
1. N=2, A=[[2,4],[1,3]], B=[[2,1],[1,1]] -> beats: [0]={2,0},{4,1},{0,3}; [1]={2,0},{1,1},{0,1}. start high on beat 0 only. Array model returns finish -> result=[[8,6],[5,4]], err=0.
2. Backpressure: hold res_ready=0 for 10 cycles after res_valid -> result stable, req_ready=0 throughout. Release -> req_ready=1 the next cycle. Second job A=B=identity -> result=identity.
3. Timeout: model never asserts finish, TIMEOUT=64 -> res_valid with err=1, result all 0, 64 cycles after entering DRAIN.
4. Reset mid-FEED: assert rst at beat 1 -> next cycle array=0, start=0, res_valid=0, req_ready=0; then req_ready=1 one cycle after release. A fresh job completes correctly.
5. Spurious finish=1 during FEED beat 1 -> ignored. Real finish in DRAIN captures Data; result matches the model.
6. N=4, WIDTH=8, random A/B against a reference model of the array -> 7 beats per job. Each lane is zero outside its skew window. 100 back-to-back jobs match.
